// File: rtl/seq_shifter.sv
// Sequential barrel-free shifter: one bit per clock, valid/ready on both sides.
// A request is captured in IDLE, shifted in SHIFT and held in DONE until consumed.
module seq_shifter #(
    parameter int WIDTH = 4,
    parameter int SHW   = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iData,
    input  logic [SHW-1:0]   iAmt,
    input  logic [1:0]       iMode,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData,
    output logic             oBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    localparam logic [SHW-1:0] CNT_ZERO = '0;
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [1:0]       mode_q, mode_d;

    // Single-bit step; amounts >= WIDTH fall out naturally from repeating it.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w,
                                                   input logic [1:0] m);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_LSL: r = {w[WIDTH-2:0], 1'b0};
            MODE_LSR: r = {1'b0, w[WIDTH-1:1]};
            MODE_ASR: r = {w[WIDTH-1], w[WIDTH-1:1]};
            default:  r = {w[WIDTH-2:0], w[WIDTH-1]};
        endcase
        return r;
    endfunction

    // State register with synchronous reset that wins over every handshake input.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            work_q  <= '0;
            mode_q  <= MODE_LSL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic: capture in IDLE, step in SHIFT, hold in DONE until consumed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (iValid) begin
                    work_d  = iData;
                    cnt_d   = iAmt;
                    mode_d  = iMode;
                    state_d = (iAmt == CNT_ZERO) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = shift_one(work_q, mode_q);
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (iReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded purely from the registered state.
    always_comb begin
        oReady = (state_q == IDLE);
        oValid = (state_q == DONE);
        oBusy  = (state_q != IDLE);
        oData  = work_q;
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: vector table, random vectors and corner sequences.
module tb_seq_shifter;

    localparam int WIDTH = 4;
    localparam int SHW   = 3;

    logic             iClk;
    logic             iRst;
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iData;
    logic [SHW-1:0]   iAmt;
    logic [1:0]       iMode;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oData;
    logic             oBusy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        logic [1:0]       mode;
        logic [WIDTH-1:0] expd;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] expd;
        int               lat;
    } sb_t;

    vec_t vecs[11];
    sb_t  sbq[$];

    seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .oReady (oReady),
        .iData  (iData),
        .iAmt   (iAmt),
        .iMode  (iMode),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (oData),
        .oBusy  (oBusy)
    );

    // Free-running clock.
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Whole-word reference written with shift operators rather than single steps.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                               input int amt,
                                               input logic [1:0] m);
        logic [WIDTH-1:0] r;
        int k;
        case (m)
            2'b00:   r = d << amt;
            2'b01:   r = d >> amt;
            2'b10:   r = $signed(d) >>> amt;
            default: begin
                k = amt % WIDTH;
                if (k == 0) r = d;
                else        r = (d << k) | (d >> (WIDTH - k));
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait for oReady, present one request for a single edge and record what must come back.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [SHW-1:0] amt,
                                 input logic [1:0] m, input logic [WIDTH-1:0] expd);
        int n = 0;
        while (!oReady && n < 50) begin
            @(negedge iClk);
            n++;
        end
        check("ready_before_request", 32'(oReady), 32'd1);
        iValid = 1'b1;
        iData  = d;
        iAmt   = amt;
        iMode  = m;
        sbq.push_back('{expd: expd, lat: int'(amt)});
        @(posedge iClk);
        @(negedge iClk);
    endtask

    // Scramble inputs while busy, then compare the result against the scoreboard and consume it.
    task automatic checkOutput();
        int  lat = 0;
        sb_t e;
        while (!oValid && lat < 40) begin
            iValid = 1'($urandom);
            iData  = WIDTH'($urandom);
            iAmt   = SHW'($urandom);
            iMode  = 2'($urandom);
            @(negedge iClk);
            lat++;
        end
        check("result_valid", 32'(oValid), 32'd1);
        if (sbq.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check("result_data", 32'(oData), 32'(e.expd));
            check("result_latency", 32'(lat), 32'(e.lat));
        end
        iValid = 1'b0;
        iReady = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iReady = 1'b0;
        check("idle_after_consume_valid", 32'(oValid), 32'd0);
        check("idle_after_consume_ready", 32'(oReady), 32'd1);
    endtask

    // Main stimulus sequence.
    initial begin
        sb_t         e;
        int          n;
        logic        seen;
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   a;
        logic [1:0]       m;

        vecs[0]  = '{4'b1011, 3'd2, 2'b00, 4'b1100};
        vecs[1]  = '{4'b1000, 3'd3, 2'b10, 4'b1111};
        vecs[2]  = '{4'b1000, 3'd3, 2'b01, 4'b0001};
        vecs[3]  = '{4'b1001, 3'd0, 2'b11, 4'b1001};
        vecs[4]  = '{4'b1001, 3'd1, 2'b11, 4'b0011};
        vecs[5]  = '{4'b0110, 3'd5, 2'b00, 4'b0000};
        vecs[6]  = '{4'b1010, 3'd7, 2'b10, 4'b1111};
        vecs[7]  = '{4'b0111, 3'd4, 2'b01, 4'b0000};
        vecs[8]  = '{4'b1001, 3'd6, 2'b11, 4'b0110};
        vecs[9]  = '{4'b0101, 3'd4, 2'b10, 4'b0000};
        vecs[10] = '{4'b1101, 3'd0, 2'b00, 4'b1101};

        iRst   = 1'b1;
        iValid = 1'b0;
        iReady = 1'b0;
        iData  = '0;
        iAmt   = '0;
        iMode  = 2'b00;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        check("reset_ready", 32'(oReady), 32'd1);
        check("reset_valid", 32'(oValid), 32'd0);
        check("reset_busy",  32'(oBusy),  32'd0);
        check("reset_data",  32'(oData),  32'd0);
        iRst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].data, vecs[i].amt, vecs[i].mode, vecs[i].expd);
            checkOutput();
        end

        for (int i = 0; i < 12; i++) begin
            d = WIDTH'($urandom);
            a = SHW'($urandom_range(0, 7));
            m = 2'($urandom);
            applyStimulus(d, a, m, model(d, int'(a), m));
            checkOutput();
        end

        // Back-pressure: result held while the consumer stalls and new requests are ignored.
        applyStimulus(4'b1011, 3'd1, 2'b00, 4'b0110);
        iValid = 1'b0;
        n = 0;
        while (!oValid && n < 40) begin
            @(negedge iClk);
            n++;
        end
        check("bp_valid_seen", 32'(oValid), 32'd1);
        e = sbq.pop_front();
        for (int k = 0; k < 5; k++) begin
            iValid = 1'b1;
            iData  = 4'b0000;
            iAmt   = 3'd0;
            iMode  = 2'b11;
            @(posedge iClk);
            @(negedge iClk);
            check("bp_hold_valid", 32'(oValid), 32'd1);
            check("bp_hold_data",  32'(oData),  32'(e.expd));
            check("bp_hold_ready", 32'(oReady), 32'd0);
        end
        iReady = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
        iReady = 1'b0;
        check("bp_release_ready", 32'(oReady), 32'd1);
        check("bp_release_valid", 32'(oValid), 32'd0);
        check("bp_no_accept_on_consume", 32'(oBusy), 32'd0);
        @(posedge iClk);
        @(negedge iClk);
        check("bp_still_idle", 32'(oBusy), 32'd0);

        // Reset on the second SHIFT edge aborts the operation; no result ever appears.
        iValid = 1'b1;
        iData  = 4'b1011;
        iAmt   = 3'd3;
        iMode  = 2'b00;
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
        check("abort_busy_after_accept", 32'(oBusy), 32'd1);
        @(posedge iClk);
        @(negedge iClk);
        iRst   = 1'b1;
        iValid = 1'b1;
        iReady = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iRst   = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        check("abort_ready", 32'(oReady), 32'd1);
        check("abort_valid", 32'(oValid), 32'd0);
        check("abort_data",  32'(oData),  32'd0);
        check("abort_busy",  32'(oBusy),  32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge iClk);
            @(negedge iClk);
            if (oValid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        // One more request after the abort to confirm normal service resumes.
        applyStimulus(4'b0011, 3'd2, 2'b01, 4'b0000);
        checkOutput();

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
